// File: rtl/score_bcd_converter.sv
// Iterative binary-to-BCD converter (shift-and-add-3) for the score/timer displays.
// The committed digits, blank mask and overflow flag stay stable while the next conversion runs.
module score_bcd_converter #(
  parameter int IN_WIDTH = 20,
  parameter int DIGITS   = 6
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  auto_mode,
  input  logic [IN_WIDTH-1:0]   value_in,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow,
  output logic                  busy,
  output logic                  done
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);

  function automatic logic [63:0] calc_max(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = calc_max(DIGITS);

  function automatic logic [SW-1:0] add3(input logic [SW-1:0] d);
    logic [SW-1:0] r;
    r = d;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = d[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = d[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Digit i is blanked only when it and every more significant digit are zero.
  function automatic logic [DIGITS-1:0] blank_of(input logic [SW-1:0] d);
    logic [DIGITS-1:0] b;
    logic              zero_above;
    b          = {DIGITS{1'b0}};
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (d[4*i +: 4] == 4'd0);
      b[i]       = zero_above;
    end
    b[0] = 1'b0;
    return b;
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t              state_r;
  logic [SW-1:0]       scratch_r;
  logic [SW-1:0]       adj_s;
  logic [IN_WIDTH-1:0] shift_r;
  logic [CW-1:0]       count_r;
  logic                sat_r;

  assign adj_s = add3(scratch_r);

  // Conversion FSM with registered outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      scratch_r <= {SW{1'b0}};
      shift_r   <= {IN_WIDTH{1'b0}};
      count_r   <= {CW{1'b0}};
      sat_r     <= 1'b0;
      bcd       <= {SW{1'b0}};
      blank     <= {{(DIGITS-1){1'b1}}, 1'b0};
      overflow  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start | auto_mode) begin
            if (64'(value_in) > MAX_VAL) begin
              shift_r <= MAX_VAL[IN_WIDTH-1:0];
              sat_r   <= 1'b1;
            end else begin
              shift_r <= value_in;
              sat_r   <= 1'b0;
            end
            scratch_r <= {SW{1'b0}};
            count_r   <= CW'(IN_WIDTH);
            busy      <= 1'b1;
            state_r   <= CONVERT;
          end else begin
            state_r <= IDLE;
          end
        end
        CONVERT: begin
          scratch_r <= (adj_s << 1) | SW'(shift_r[IN_WIDTH-1]);
          shift_r   <= shift_r << 1;
          count_r   <= count_r - CW'(1);
          if (count_r == CW'(1)) begin
            state_r <= COMMIT;
          end else begin
            state_r <= CONVERT;
          end
        end
        COMMIT: begin
          bcd      <= scratch_r;
          blank    <= blank_of(scratch_r);
          overflow <= sat_r;
          done     <= 1'b1;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed, table-driven bench for score_bcd_converter with hand-computed expected digits.
module tb_score_bcd_converter;

  logic        clock;
  logic        rst_n;
  logic        start;
  logic        auto_mode;
  logic [19:0] value_in;
  logic [23:0] bcd;
  logic [5:0]  blank;
  logic        overflow;
  logic        busy;
  logic        done;

  int n_cmp;
  int n_fail;
  int cyc;

  score_bcd_converter #(.IN_WIDTH(20), .DIGITS(6)) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .start    (start),
    .auto_mode(auto_mode),
    .value_in (value_in),
    .bcd      (bcd),
    .blank    (blank),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] val;
    logic [23:0] exp_bcd;
    logic [5:0]  exp_blank;
    logic        exp_ovf;
    int          mode;   // 0 plain, 1 value_in changes mid-run, 2 extra start mid-run
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic convert(input logic [19:0] v, input logic [23:0] eb, input logic [5:0] ebl,
                         input logic eo, input int mode);
    int          cycles;
    int          busy_cnt;
    int          extra;
    logic [23:0] prev;
    prev     = bcd;
    value_in = v;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start    = 1'b0;
    busy_cnt = busy ? 1 : 0;
    cycles   = 0;
    while (cycles < 40) begin
      @(posedge clock);
      #1;
      cycles++;
      if (done) break;
      if (busy) busy_cnt++;
      if (bcd !== prev) check("bcd_hold", 32'(bcd), 32'(prev));
      if (cycles == 5 && mode == 1) value_in = 20'd999;
      if (cycles == 5 && mode == 2) begin
        value_in = 20'd777;
        start    = 1'b1;
      end
      if (cycles == 6) start = 1'b0;
    end
    check("latency", 32'(cycles), 32'd21);
    check("busy_cycles", 32'(busy_cnt), 32'd21);
    check("bcd", 32'(bcd), 32'(eb));
    check("blank", 32'(blank), 32'(ebl));
    check("overflow", 32'(overflow), 32'(eo));
    check("busy_after", 32'(busy), 32'd0);
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clock);
      #1;
      if (done) extra++;
    end
    check("no_extra_done", 32'(extra), 32'd0);
    check("bcd_stable", 32'(bcd), 32'(eb));
  endtask

  initial begin
    int          last_cyc;
    int          cycles;
    int          dcount;
    logic [19:0] auto_vals[3];
    logic [23:0] auto_bcd[3];
    logic [5:0]  auto_blank[3];
    logic [23:0] prev;

    n_cmp = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0; start = 1'b0; auto_mode = 1'b0; value_in = 20'd0;

    vecs[0] = '{20'd0,       24'h000000, 6'b111110, 1'b0, 0};
    vecs[1] = '{20'd123456,  24'h123456, 6'b000000, 1'b0, 1};
    vecs[2] = '{20'd1048575, 24'h999999, 6'b000000, 1'b1, 0};
    vecs[3] = '{20'd1000,    24'h001000, 6'b110000, 1'b0, 0};
    vecs[4] = '{20'd4242,    24'h004242, 6'b110000, 1'b0, 2};
    vecs[5] = '{20'd999999,  24'h999999, 6'b000000, 1'b0, 0};
    vecs[6] = '{20'd1000000, 24'h999999, 6'b000000, 1'b1, 0};
    vecs[7] = '{20'd10,      24'h000010, 6'b111100, 1'b0, 0};
    vecs[8] = '{20'd100000,  24'h100000, 6'b000000, 1'b0, 0};
    vecs[9] = '{20'd5,       24'h000005, 6'b111110, 1'b0, 0};

    repeat (3) @(posedge clock);
    #1;
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_blank", 32'(blank), 32'(6'b111110));
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 10; i++) begin
      convert(vecs[i].val, vecs[i].exp_bcd, vecs[i].exp_blank, vecs[i].exp_ovf, vecs[i].mode);
    end

    // Free-running auto mode: a new value is presented on each done cycle.
    auto_vals  = '{20'd7, 20'd42, 20'd65535};
    auto_bcd   = '{24'h000007, 24'h000042, 24'h065535};
    auto_blank = '{6'b111110, 6'b111100, 6'b100000};
    value_in  = auto_vals[0];
    auto_mode = 1'b1;
    last_cyc  = 0;
    for (int j = 0; j < 3; j++) begin
      prev   = bcd;
      cycles = 0;
      while (cycles < 40) begin
        @(posedge clock);
        #1;
        cycles++;
        if (done) break;
        if (bcd !== prev) check("auto_hold", 32'(bcd), 32'(prev));
      end
      check("auto_done_seen", 32'(done), 32'd1);
      check("auto_bcd", 32'(bcd), 32'(auto_bcd[j]));
      check("auto_blank", 32'(blank), 32'(auto_blank[j]));
      if (j > 0) check("auto_period", 32'(cyc - last_cyc), 32'd22);
      last_cyc = cyc;
      if (j < 2) value_in = auto_vals[j+1];
      else auto_mode = 1'b0;
    end
    repeat (30) @(posedge clock);
    #1;
    check("auto_idle_busy", 32'(busy), 32'd0);

    // Reset asserted partway through a conversion aborts it.
    value_in = 20'd654321;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_bcd", 32'(bcd), 32'h0);
    check("abort_blank", 32'(blank), 32'(6'b111110));
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    @(negedge clock);
    @(negedge clock);
    rst_n  = 1'b1;
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock);
      #1;
      if (done | busy) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);
    convert(20'd31, 24'h000031, 6'b111100, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
